// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte
// sources. Latches the winner's byte, pulses tx_start once, then follows
// tx_busy until the frame ends (or never starts, which raises err_timeout).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame in flight; arbitrate when a req is up and tx is free
// LAUNCH    | single cycle carrying ack and tx_start for the granted byte
// WAIT_BUSY | waiting for uart_tx to raise busy; timed out by the counter
// WAIT_DONE | frame on the wire; leave when busy falls
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 1024,
  localparam int OWN_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [OWN_W-1:0]          owner,
  output logic                      active,
  output logic                      err_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state, state_nxt;
  logic [OWN_W-1:0]    last_grant, last_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]  ack_nxt;
  logic                tx_start_nxt;
  logic [DATA_W-1:0]   tx_data_nxt;
  logic [OWN_W-1:0]    owner_nxt;
  logic                active_nxt;
  logic                err_nxt;

  logic                grant_vld;
  logic [OWN_W-1:0]    grant_idx;
  logic [OWN_W-1:0]    cand;
  logic [DATA_W-1:0]   sel_data;

  // Round-robin search: start just after the last winner and wrap, so a
  // requester that keeps req high cannot starve the others.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = OWN_W'((int'(last_grant) + 1 + i) % NUM_REQ);
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Byte mux for the winning requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == OWN_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last_grant;
    cnt_nxt      = cnt;
    ack_nxt      = '0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    owner_nxt    = owner;
    active_nxt   = active;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        // A busy transmitter here is a foreign or leftover frame: hold off.
        if (grant_vld && !tx_busy) begin
          state_nxt    = LAUNCH;
          tx_data_nxt  = sel_data;
          owner_nxt    = grant_idx;
          last_nxt     = grant_idx;
          ack_nxt      = NUM_REQ'(1) << grant_idx;
          tx_start_nxt = 1'b1;
          active_nxt   = 1'b1;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT_BUSY;
        cnt_nxt   = '0;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // last_grant keeps the failed requester so the others go next.
          state_nxt  = IDLE;
          err_nxt    = 1'b1;
          active_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_nxt  = IDLE;
          active_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset points last_grant at the top index
  // so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= OWN_W'(NUM_REQ - 1);
      cnt         <= '0;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      owner       <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_nxt;
      cnt         <= cnt_nxt;
      ack         <= ack_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
      owner       <= owner_nxt;
      active      <= active_nxt;
      err_timeout <= err_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by
// randomized request patterns, checked against a round-robin reference.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BT = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   ack;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic [1:0]      owner;
  logic            active;
  logic            err_timeout;

  int n_assert = 0;
  int n_fail   = 0;
  int model_last;

  int busy_delay = 2;
  int busy_len   = 10;
  bit busy_never = 1'b0;
  int bphase = 0;
  int bcnt   = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .owner(owner), .active(active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy rises busy_delay cycles after tx_start and
  // stays up busy_len cycles; shares rst with the arbiter.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_busy = 1'b0;
        bphase  = 0;
      end else begin
        case (bphase)
          0: if (tx_start && !busy_never) begin bcnt = busy_delay; bphase = 1; end
          1: begin
            bcnt--;
            if (bcnt == 0) begin tx_busy = 1'b1; bcnt = busy_len; bphase = 2; end
          end
          2: begin
            bcnt--;
            if (bcnt == 0) begin tx_busy = 1'b0; bphase = 0; end
          end
          default: bphase = 0;
        endcase
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Round-robin reference: first set bit after 'last', wrapping.
  function automatic int pick(logic [NR-1:0] r, int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int maxc, output int n);
    n = 0;
    do begin
      step;
      n++;
    end while (ack == '0 && n < maxc);
  endtask

  task automatic wait_idle(input int maxc, output int n, output int fall_n);
    logic prev;
    n = 0;
    fall_n = -1;
    prev = tx_busy;
    do begin
      step;
      n++;
      if (prev && !tx_busy && fall_n < 0) fall_n = n;
      prev = tx_busy;
    end while (active && n < maxc);
    chk("wait_idle_done", {31'b0, active}, 0);
  endtask

  // Expect a grant on the very next cycle, matching the reference pick.
  task automatic grant_check(input string tag, output int g);
    int n;
    logic [DW-1:0] ed;
    g  = pick(req, model_last);
    ed = req_data[g*DW +: DW];
    wait_ack(200, n);
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_ack"}, {28'b0, ack}, 32'(1) << g);
    chk({tag, "_onehot"}, {31'b0, $onehot(ack)}, 1);
    chk({tag, "_start"}, {31'b0, tx_start}, 1);
    chk({tag, "_data"}, {24'b0, tx_data}, {24'b0, ed});
    chk({tag, "_owner"}, {30'b0, owner}, g);
    chk({tag, "_active"}, {31'b0, active}, 1);
    model_last = g;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {28'b0, ack}, 0);
    chk({tag, "_start"}, {31'b0, tx_start}, 0);
    chk({tag, "_data"}, {24'b0, tx_data}, 0);
    chk({tag, "_owner"}, {30'b0, owner}, 0);
    chk({tag, "_active"}, {31'b0, active}, 0);
    chk({tag, "_err"}, {31'b0, err_timeout}, 0);
  endtask

  initial begin
    int g, n, f;
    logic [DW-1:0] ed;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    repeat (3) step;
    chk_all_zero("reset");
    rst = 1'b0;
    model_last = NR - 1;

    // 1: single request, A5 from requester 0
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    busy_delay = 2; busy_len = 100;
    grant_check("t1", g);
    chk("t1_ack0", {28'b0, ack}, 1);
    req = '0;
    step;
    chk("t1_start_pulse", {31'b0, tx_start}, 0);
    chk("t1_ack_pulse", {28'b0, ack}, 0);
    wait_idle(500, n, f);
    chk("t1_active_drop", n, f + 1);
    chk("t1_owner_hold", {30'b0, owner}, 0);
    chk("t1_err", {31'b0, err_timeout}, 0);

    // 2: all four requesting, fresh round-robin from reset
    rst = 1'b1; step; rst = 1'b0;
    model_last = NR - 1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'h10 + 8'(i);
    busy_delay = 2; busy_len = 5;
    req = 4'b1111;
    for (int fr = 0; fr < 5; fr++) begin
      grant_check("t2", g);
      chk("t2_order", {28'b0, ack}, 32'(1) << (fr % 4));
      chk("t2_byte", {24'b0, tx_data}, 32'h10 + 32'(fr % 4));
      wait_idle(500, n, f);
      if (fr == 4) req = '0;
    end

    // 3: last_grant=1, then 0101 -> 2 before 0
    req_data = 32'hC4B3A291;
    req = 4'b0010;
    grant_check("t3a", g);
    req = '0;
    wait_idle(500, n, f);
    req = 4'b0101;
    grant_check("t3b", g);
    chk("t3b_is2", {28'b0, ack}, 4'b0100);
    req[2] = 1'b0;
    wait_idle(500, n, f);
    grant_check("t3c", g);
    chk("t3c_is0", {28'b0, ack}, 4'b0001);
    req = '0;
    wait_idle(500, n, f);

    // 4: transmitter never goes busy -> timeout, then pending req served
    busy_never = 1'b1;
    req = 4'b0011;
    grant_check("t4a", g);
    req[g] = 1'b0;
    wait_idle(BT + 50, n, f);
    chk("t4_timeout_cycles", n, BT + 1);
    chk("t4_err", {31'b0, err_timeout}, 1);
    busy_never = 1'b0;
    grant_check("t4b", g);
    chk("t4_err_pulse", {31'b0, err_timeout}, 0);
    req = '0;
    wait_idle(500, n, f);

    // 5: reset in WAIT_DONE with requester 1 pending
    busy_delay = 2; busy_len = 50;
    req = 4'b1000;
    grant_check("t5a", g);
    req = '0;
    repeat (6) step;
    chk("t5_in_frame", {31'b0, active}, 1);
    req = 4'b0010;
    rst = 1'b1;
    step;
    chk_all_zero("t5_rst");
    rst = 1'b0;
    model_last = NR - 1;
    grant_check("t5b", g);
    chk("t5b_is1", {28'b0, ack}, 4'b0010);
    req = '0;
    wait_idle(500, n, f);

    // 6: requester changes its byte right after ack
    busy_len = 30;
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    grant_check("t6", g);
    req = '0;
    req_data[7:0] = 8'h3C;
    repeat (10) step;
    chk("t6_data_mid", {24'b0, tx_data}, 32'hA5);
    wait_idle(500, n, f);
    chk("t6_data_end", {24'b0, tx_data}, 32'hA5);

    // Randomized request patterns
    for (int it = 0; it < 40; it++) begin
      if (req == '0) req = 4'($urandom_range(1, 15));
      req_data = $urandom;
      busy_delay = $urandom_range(1, 4);
      busy_len = $urandom_range(1, 12);
      grant_check("rnd", g);
      ed = req_data[g*DW +: DW];
      req[g] = 1'b0;
      if ($urandom_range(0, 1) == 1) req = req | 4'($urandom_range(0, 15));
      req_data = $urandom;
      wait_idle(500, n, f);
      chk("rnd_active_drop", n, f + 1);
      chk("rnd_data_hold", {24'b0, tx_data}, {24'b0, ed});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
